// File: rtl/tt_bist_harness.sv
// tt_bist_harness
//   Built-in self-test wrapper between the pin ring and the core. A start
//   request resets the core for RST_CYCLES cycles. The harness then drives
//   LFSR stimulus for CYCLES+RESP_LAT cycles and folds the core's responses
//   into a MISR. On completion it compares the MISR against `golden`.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   ena               advance enable; when low every register holds
//   start             begin a self-test (honoured in IDLE/DONE only)
//   golden[W]         expected signature, sampled once on DONE entry
//   core_rst_n        registered reset to the core
//   stim[W]           registered stimulus to the core
//   resp[W]           core response
//   busy, done, pass  status; pass is valid while done is high
//   signature[W]      live MISR value
module tt_bist_harness #(
  parameter int               WIDTH      = 8,
  parameter int               CYCLES     = 256,
  parameter int               RST_CYCLES = 2,
  parameter int               RESP_LAT   = 0,
  parameter logic [WIDTH-1:0] SEED       = 8'h01,
  parameter logic [WIDTH-1:0] LFSR_POLY  = 8'hB8,
  parameter logic [WIDTH-1:0] MISR_POLY  = 8'hB8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] golden,
  output logic             core_rst_n,
  output logic [WIDTH-1:0] stim,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int RUN_LEN = CYCLES + RESP_LAT;
  localparam int CNT_MAX = (RUN_LEN > RST_CYCLES) ? RUN_LEN : RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] LAT_C    = CW'(RESP_LAT);

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] misr;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] misr_nxt;
  logic             cap_en;

  assign lfsr_nxt = {lfsr[WIDTH-2:0], ^(lfsr & LFSR_POLY)};
  assign misr_nxt = {misr[WIDTH-2:0], ^(misr & MISR_POLY)} ^ resp;

  // The first RESP_LAT RUN cycles only fill the core pipeline. Their
  // responses belong to no stimulus, so they are not compressed.
  generate
    if (RESP_LAT == 0) begin : g_nolat
      assign cap_en = 1'b1;
    end else begin : g_lat
      assign cap_en = (cnt >= LAT_C);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      core_rst_n <= 1'b0;
      stim       <= '0;
      lfsr       <= SEED_EFF;
      misr       <= '0;
      cnt        <= '0;
      pass       <= 1'b0;
    end else if (ena) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RESET;
            cnt        <= '0;
            lfsr       <= SEED_EFF;
            misr       <= '0;
            pass       <= 1'b0;
            core_rst_n <= 1'b0;
            stim       <= SEED_EFF;
          end else if (state == S_IDLE) begin
            core_rst_n <= 1'b1;
            stim       <= '0;
          end
        end
        S_RESET: begin
          if (cnt == RST_LAST) begin
            state      <= S_RUN;
            cnt        <= '0;
            core_rst_n <= 1'b1;
            // stim tracks the LFSR register so that it is aligned with the
            // RUN state.
            stim       <= lfsr;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RUN: begin
          lfsr <= lfsr_nxt;
          stim <= lfsr_nxt;
          if (cap_en) misr <= misr_nxt;
          if (cnt == RUN_LAST) begin
            // The last capture is always active here because CYCLES >= 1.
            state <= S_DONE;
            pass  <= (misr_nxt == golden);
            stim  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_RESET) || (state == S_RUN);
  assign done      = (state == S_DONE);
  assign signature = misr;

endmodule
